div_shift_sub_seq: RTL and testbench
====================================

// Module: div_shift_sub_seq
// PURPOSE
//  Sequential restoring divider: shift-subtract inverse of the shift-add multiplier stages in the FFT datapath.
//  Divides an unsigned DIVIDEND_W-bit value by an unsigned DIVISOR_W-bit value, one quotient bit per clock.
//  Used after the FFT to normalise magnitudes and energies (e.g. bin power / frame energy) before feature extraction.
// PARAMETERS
//  DIVIDEND_W  16  dividend and quotient width, also the number of iterations
//  DIVISOR_W   8   divisor and remainder width
// PORTS
//  clk           in   1            system clock, rising edge
//  rst_n         in   1            synchronous reset, active low
//  start         in   1            request; sampled only in IDLE
//  dividend      in   DIVIDEND_W   unsigned numerator, sampled with start
//  divisor       in   DIVISOR_W    unsigned denominator, sampled with start
//  busy          out  1            high in RUN and DONE; start is ignored while high
//  rdy           out  1            one-cycle pulse: result valid
//  quotient      out  DIVIDEND_W   unsigned quotient, held until next rdy
//  remainder     out  DIVISOR_W    unsigned remainder, held until next rdy
//  div_by_zero   out  1            flag for the last result, held until next rdy
// BEHAVIOUR
//  - Reset: all outputs 0, state IDLE, internal regs 0. Checked only on a clk edge.
//  - Reset mid-operation aborts the operation. No rdy follows. Outputs clear to 0.
//  - States: IDLE, RUN, DONE. All outputs are registered.
//  - IDLE, start=1, divisor!=0:
//    - latch dividend into the shift reg. Clear the partial remainder.
//    - cnt <= DIVIDEND_W. Go to RUN; busy <= 1.
//  - IDLE, start=1, divisor==0:
//    - go to DONE; rdy <= 1; div_by_zero <= 1.
//    - quotient <= all ones; remainder <= 0.
//  - RUN, each edge:
//    - prem = {rem, msb of shift reg} (DIVISOR_W+1 bits); shift reg <<= 1.
//    - if prem >= divisor: rem <= prem - divisor and quotient LSB <= 1. Otherwise rem <= prem[DIVISOR_W-1:0] and LSB <= 0.
//    - cnt <= cnt-1.
//  - Last RUN edge (cnt==1):
//    - write final quotient and remainder to the outputs; div_by_zero <= 0.
//    - rdy <= 1; go to DONE.
//  - DONE: next edge rdy <= 0, busy <= 0; go to IDLE.
//  - Latency, with start sampled on edge 0:
//    - normal: rdy is high in the cycle after edge DIVIDEND_W (16 for defaults).
//    - div-by-zero: rdy is high in the cycle after edge 0.
//    - next start is accepted on the edge after the rdy cycle (IDLE).
//  - start while busy: ignored. Latched operands and the result are unaffected.
//  - Invariants:
//    - remainder < divisor whenever divisor != 0.
//    - quotient*divisor + remainder == dividend (exact, no saturation).
//  - The quotient can use the full DIVIDEND_W bits (divisor=1). No overflow case exists.
// TESTING
//  1. 1000/7 -> quotient=142, remainder=6, div_by_zero=0; rdy exactly 16 cycles after start, one cycle wide.
//  2. 0xFFFF/0xFF -> quotient=257, remainder=0. Then 0xFFFF/1 -> quotient=0xFFFF, remainder=0.
//  3. 5/9 -> quotient=0, remainder=5. Then 0/3 -> quotient=0, remainder=0.
//  4. 1234/0 -> next cycle rdy=1, div_by_zero=1, quotient=0xFFFF, remainder=0. Busy drops one cycle later.
//  5. start 1000/7, then pulse start with 50/5 at cycle 5 -> ignored; result 142 r 6 at cycle 16.
//  6. start 1000/7; rst_n=0 at cycle 8 -> no rdy, outputs 0, IDLE. After release, 100/10 -> quotient=10, remainder=0 in 16 cycles.
//  - Also: random sweep against a reference model with back-to-back starts; check the invariants on every rdy.

Source files
------------

// File: rtl/div_shift_sub_seq.sv
`default_nettype none
// ============================================================================
// Module      : div_shift_sub_seq
// Description : Sequential restoring divider. It divides an unsigned
//               DIVIDEND_W-bit value by an unsigned DIVISOR_W-bit value and
//               produces one quotient bit per clock. A zero divisor returns
//               an all-ones quotient and sets div_by_zero.
// Revision    : 1.0 - initial release
// ============================================================================
module div_shift_sub_seq #(
  parameter int DIVIDEND_W = 16,
  parameter int DIVISOR_W  = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [DIVIDEND_W-1:0] dividend,
  input  logic [DIVISOR_W-1:0]  divisor,
  output logic                  busy,
  output logic                  rdy,
  output logic [DIVIDEND_W-1:0] quotient,
  output logic [DIVISOR_W-1:0]  remainder,
  output logic                  div_by_zero
);

  localparam int CNT_W = $clog2(DIVIDEND_W + 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t                 state_q;
  // The shift register starts out holding the dividend. On each RUN step
  // its MSB moves into the partial remainder, and the new quotient bit
  // enters at its LSB. After DIVIDEND_W steps it holds only quotient bits.
  logic [DIVIDEND_W-1:0]  sreg_q;
  logic [DIVISOR_W-1:0]   rem_q;
  logic [DIVISOR_W-1:0]   dsr_q;
  logic [CNT_W-1:0]       cnt_q;
  logic                   busy_q;
  logic                   rdy_q;
  logic [DIVIDEND_W-1:0]  quot_q;
  logic [DIVISOR_W-1:0]   remo_q;
  logic                   dz_q;

  logic [DIVISOR_W:0]     prem_d;
  logic [DIVISOR_W:0]     diff_d;
  logic                   qbit_d;
  logic [DIVISOR_W-1:0]   rem_d;
  logic [DIVIDEND_W-1:0]  sreg_d;

  // One restoring step: trial-subtract the divisor from the widened
  // partial remainder, then keep the difference only when it does not
  // underflow.
  always_comb begin
    prem_d = {rem_q, sreg_q[DIVIDEND_W-1]};
    diff_d = prem_d - {1'b0, dsr_q};
    qbit_d = (prem_d >= {1'b0, dsr_q});
    rem_d  = qbit_d ? diff_d[DIVISOR_W-1:0] : prem_d[DIVISOR_W-1:0];
    sreg_d = {sreg_q[DIVIDEND_W-2:0], qbit_d};
  end

  // Control FSM and datapath registers. Every output is registered.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      sreg_q  <= '0;
      rem_q   <= '0;
      dsr_q   <= '0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      rdy_q   <= 1'b0;
      quot_q  <= '0;
      remo_q  <= '0;
      dz_q    <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          rdy_q <= 1'b0;
          if (start) begin
            busy_q <= 1'b1;
            if (divisor == '0) begin
              // A zero divisor skips the iteration and reports at once.
              state_q <= S_DONE;
              rdy_q   <= 1'b1;
              dz_q    <= 1'b1;
              quot_q  <= '1;
              remo_q  <= '0;
            end else begin
              state_q <= S_RUN;
              sreg_q  <= dividend;
              rem_q   <= '0;
              dsr_q   <= divisor;
              cnt_q   <= CNT_W'(DIVIDEND_W);
            end
          end
        end
        S_RUN: begin
          sreg_q <= sreg_d;
          rem_q  <= rem_d;
          cnt_q  <= cnt_q - CNT_W'(1);
          if (cnt_q == CNT_W'(1)) begin
            state_q <= S_DONE;
            quot_q  <= sreg_d;
            remo_q  <= rem_d;
            dz_q    <= 1'b0;
            rdy_q   <= 1'b1;
          end
        end
        S_DONE: begin
          rdy_q   <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
          rdy_q   <= 1'b0;
        end
      endcase
    end
  end

  assign busy        = busy_q;
  assign rdy         = rdy_q;
  assign quotient    = quot_q;
  assign remainder   = remo_q;
  assign div_by_zero = dz_q;

endmodule
`default_nettype wire

// File: tb/tb_div_shift_sub_seq.sv
`default_nettype none
// ============================================================================
// Module      : tb_div_shift_sub_seq
// Description : Self-checking bench for div_shift_sub_seq. The reference
//               model predicts results from integer division and tracks
//               latency as edge numbers. Directed cases pin literal values.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_div_shift_sub_seq;

  localparam int DW = 16;
  localparam int VW = 8;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic [DW-1:0] dividend = '0;
  logic [VW-1:0] divisor = '0;
  logic          busy, rdy, div_by_zero;
  logic [DW-1:0] quotient;
  logic [VW-1:0] remainder;

  div_shift_sub_seq #(.DIVIDEND_W(DW), .DIVISOR_W(VW)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .dividend(dividend),
    .divisor(divisor), .busy(busy), .rdy(rdy), .quotient(quotient),
    .remainder(remainder), .div_by_zero(div_by_zero)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: a result is due at a known edge number. Busy is high
  // from the accept edge through the result edge. A new start is accepted
  // only two edges after the previous result edge.
  longint        edge_n = 0;
  longint        t_done = -10;
  logic [DW-1:0] pq, exp_q = '0;
  logic [VW-1:0] pr, exp_r = '0;
  logic          pdz, exp_dz = 1'b0, exp_rdy = 1'b0, exp_busy = 1'b0;
  longint        pa = 0, pb = 0;

  // Advance the model on every rising edge using the inputs it sampled.
  always @(posedge clk) begin
    edge_n++;
    if (!rst_n) begin
      t_done = -10;
      exp_q = '0; exp_r = '0; exp_dz = 1'b0; exp_rdy = 1'b0; exp_busy = 1'b0;
    end else begin
      exp_rdy = 1'b0;
      if (start && edge_n >= t_done + 2) begin
        pa = dividend; pb = divisor;
        if (divisor == '0) begin
          t_done = edge_n; pq = '1; pr = '0; pdz = 1'b1;
        end else begin
          t_done = edge_n + DW;
          pq  = DW'(pa / pb);
          pr  = VW'(pa % pb);
          pdz = 1'b0;
        end
      end
      if (edge_n == t_done) begin
        exp_q = pq; exp_r = pr; exp_dz = pdz; exp_rdy = 1'b1;
      end
      exp_busy = (edge_n <= t_done);
    end
  end

  // Compare the DUT against the model on each falling edge. On every
  // result that is not a divide-by-zero, also check the division invariants.
  always @(negedge clk) begin
    if (edge_n > 0) begin
      chk("busy", busy, exp_busy);
      chk("rdy", rdy, exp_rdy);
      chk("quotient", quotient, exp_q);
      chk("remainder", remainder, exp_r);
      chk("div_by_zero", div_by_zero, exp_dz);
      if (rdy && !div_by_zero && exp_rdy && pb != 0) begin
        chk("inv_q*d+r", longint'(quotient) * pb + longint'(remainder), pa);
        chk("inv_r<d", longint'(remainder) < pb, 1);
      end
    end
  end

  // Run one division. junk=1 pulses a spurious start 5 cycles in, and
  // junk=2 toggles random spurious starts while busy.
  task automatic run_op(input logic [DW-1:0] a, input logic [VW-1:0] b, input int junk,
                        input bit lit, input logic [DW-1:0] eq, input logic [VW-1:0] er);
    int w, lat;
    w = 0;
    while (busy && w < 40) begin
      @(negedge clk);
      w++;
    end
    if (busy) chk("idle_timeout", 1, 0);
    start = 1'b1; dividend = a; divisor = b;
    @(negedge clk);
    start = 1'b0;
    lat = 0;
    while (!rdy && lat < 40) begin
      if (junk == 1) begin
        start = (lat == 4); dividend = DW'(50); divisor = VW'(5);
      end else if (junk == 2) begin
        start = 1'($urandom_range(0, 1)); dividend = DW'($urandom); divisor = VW'($urandom);
      end
      @(negedge clk);
      lat++;
    end
    start = 1'b0;
    chk("latency", lat, (b == '0) ? 0 : DW);
    chk("rdy_seen", rdy, 1);
    if (lit) begin
      chk("lit_quotient", quotient, eq);
      chk("lit_remainder", remainder, er);
      chk("lit_dz", div_by_zero, (b == '0));
    end
    @(negedge clk);
    chk("rdy_width", rdy, 0);
    chk("busy_drop", busy, 0);
  endtask

  // Stimulus sequence: reset, directed cases, then a random sweep.
  initial begin
    logic [DW-1:0] ra;
    logic [VW-1:0] rb;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_rdy", rdy, 0);
    chk("rst_quotient", quotient, 0);
    chk("rst_remainder", remainder, 0);
    chk("rst_dz", div_by_zero, 0);
    rst_n = 1'b1;
    @(negedge clk);

    run_op(16'd1000, 8'd7, 0, 1'b1, 16'd142, 8'd6);
    run_op(16'hFFFF, 8'hFF, 0, 1'b1, 16'd257, 8'd0);
    run_op(16'hFFFF, 8'd1, 0, 1'b1, 16'hFFFF, 8'd0);
    run_op(16'd5, 8'd9, 0, 1'b1, 16'd0, 8'd5);
    run_op(16'd0, 8'd3, 0, 1'b1, 16'd0, 8'd0);
    run_op(16'd1234, 8'd0, 0, 1'b1, 16'hFFFF, 8'd0);
    run_op(16'd1000, 8'd7, 1, 1'b1, 16'd142, 8'd6);

    // Reset in the middle of an operation.
    start = 1'b1; dividend = 16'd1000; divisor = 8'd7;
    @(negedge clk);
    start = 1'b0;
    repeat (7) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    chk("abort_busy", busy, 0);
    chk("abort_rdy", rdy, 0);
    chk("abort_quotient", quotient, 0);
    chk("abort_remainder", remainder, 0);
    rst_n = 1'b1;
    repeat (20) begin
      @(negedge clk);
      chk("abort_no_rdy", rdy, 0);
    end
    run_op(16'd100, 8'd10, 0, 1'b1, 16'd10, 8'd0);

    // Random back-to-back sweep with spurious starts while busy.
    for (int i = 0; i < 150; i++) begin
      case ($urandom_range(0, 9))
        0:       ra = '0;
        1:       ra = '1;
        default: ra = DW'($urandom);
      endcase
      case ($urandom_range(0, 9))
        0:       rb = '0;
        1:       rb = VW'(1);
        2:       rb = '1;
        default: rb = VW'($urandom);
      endcase
      run_op(ra, rb, 2, 1'b0, '0, '0);
    end

    repeat (2) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
